// File: rtl/comparator_pkg.sv
// Shared constants for the magnitude comparator: result encoding and width limit.
// No logic of its own; imported by the comparator top.
// Result encoding is one-hot {l,e,g}.
package comparator_pkg;

    // Widest operand the comparator is meant to be built with.
    localparam int CMP_WIDTH_MAX = 64;

    // One-hot result encoding, bit order {l, e, g}.
    localparam logic [2:0] CMP_LT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_GT = 3'b001;

    // Fold the (lt, eq) pair from the compare tree into the one-hot result.
    // Equality wins so that a malformed (lt=1, eq=1) pair can never produce two hot bits.
    function automatic logic [2:0] cmp_encode(input logic lt, input logic eq);
        logic [2:0] res;
        if (eq) begin
            res = CMP_EQ;
        end else if (lt) begin
            res = CMP_LT;
        end else begin
            res = CMP_GT;
        end
        return res;
    endfunction

endpackage

// File: rtl/cmp_cell.sv
// Slice comparator: reports a < b and a == b for one unsigned bit-slice.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs.
module cmp_cell #(
    parameter int SLICE_W = 1
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic               lt,
    output logic               eq
);

    // Slice-local unsigned compare; the parent chains slices MSB-first.
    always_comb begin
        lt = (a < b);
        eq = (a == b);
    end

endmodule

// File: rtl/comparator.sv
// Registered magnitude comparator producing one-hot l/e/g for a vs b, optionally signed.
// Latency: 1 cycle from in_valid to out_valid; l/e/g hold their value on idle cycles.
// Backpressure: none; accepts a new operand pair every cycle.
module comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter bit SIGNED_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             signed_mode,
    output logic             l,
    output logic             e,
    output logic             g,
    output logic             out_valid
);

    // Inverting both sign bits maps two's-complement order onto unsigned order,
    // so a single unsigned tree serves both modes. Equality is unaffected because
    // both operands are flipped identically.
    logic             flip_msb;
    logic [WIDTH-1:0] msb_mask;
    logic [WIDTH-1:0] a_adj;
    logic [WIDTH-1:0] b_adj;

    // Per-bit cell results and the MSB-first running (lt, eq) chain.
    // Index WIDTH is the seed: nothing decided yet, everything equal so far.
    logic [WIDTH-1:0] bit_lt;
    logic [WIDTH-1:0] bit_eq;
    logic [WIDTH:0]   lt_chain;
    logic [WIDTH:0]   eq_chain;
    logic [2:0]       res;

    assign flip_msb = SIGNED_EN && signed_mode;

    // Build the sign-bit mask without zero-width replications so WIDTH=1 is legal.
    always_comb begin
        msb_mask            = '0;
        msb_mask[WIDTH-1]   = flip_msb;
    end

    assign a_adj = a ^ msb_mask;
    assign b_adj = b ^ msb_mask;

    assign lt_chain[WIDTH] = 1'b0;
    assign eq_chain[WIDTH] = 1'b1;

    // The first differing bit from the MSB decides; lower bits only matter while equal so far.
    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_bit
        cmp_cell #(
            .SLICE_W (1)
        ) u_cell (
            .a  (a_adj[i]),
            .b  (b_adj[i]),
            .lt (bit_lt[i]),
            .eq (bit_eq[i])
        );

        assign lt_chain[i] = lt_chain[i+1] | (eq_chain[i+1] & bit_lt[i]);
        assign eq_chain[i] = eq_chain[i+1] & bit_eq[i];
    end

    assign res = cmp_encode(lt_chain[0], eq_chain[0]);

    // Output register: reset clears everything; idle cycles drop out_valid but keep l/e/g.
    always_ff @(posedge clk) begin
        if (rst) begin
            l         <= 1'b0;
            e         <= 1'b0;
            g         <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                {l, e, g} <= res;
            end
        end
    end

endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench for comparator: three instances (1-bit unsigned, 1-bit signed, 8-bit signed).
// Stimulus pushes hand-computed {l,e,g} into per-instance queues; a monitor pops on out_valid.
// Reset, hold-on-idle and out_valid timing are checked directly by the stimulus process.
module tb_comparator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       a1u, b1u, v1u, sm1u, l1u, e1u, g1u, ov1u;
    logic       a1s, b1s, v1s, sm1s, l1s, e1s, g1s, ov1s;
    logic [7:0] a8, b8;
    logic       v8, sm8, l8, e8, g8, ov8;

    logic [2:0] q1u[$];
    logic [2:0] q1s[$];
    logic [2:0] q8[$];
    logic [2:0] last8;

    int errors = 0;
    int checks = 0;

    comparator #(.WIDTH(1), .SIGNED_EN(1'b0)) dut_1u (
        .clk(clk), .rst(rst), .a(a1u), .b(b1u), .in_valid(v1u), .signed_mode(sm1u),
        .l(l1u), .e(e1u), .g(g1u), .out_valid(ov1u)
    );

    comparator #(.WIDTH(1), .SIGNED_EN(1'b1)) dut_1s (
        .clk(clk), .rst(rst), .a(a1s), .b(b1s), .in_valid(v1s), .signed_mode(sm1s),
        .l(l1s), .e(e1s), .g(g1s), .out_valid(ov1s)
    );

    comparator #(.WIDTH(8), .SIGNED_EN(1'b1)) dut_8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8), .signed_mode(sm8),
        .l(l8), .e(e8), .g(g8), .out_valid(ov8)
    );

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        v1u = 1'b0;
        v1s = 1'b0;
        v8  = 1'b0;
    endtask

    task automatic drv1u(input logic a, input logic b, input logic sm, input logic [2:0] exp);
        a1u = a; b1u = b; sm1u = sm; v1u = 1'b1;
        q1u.push_back(exp);
        step();
        chk("d1u_out_valid", 8'(ov1u), 8'd1);
    endtask

    task automatic drv1s(input logic a, input logic b, input logic sm, input logic [2:0] exp);
        a1s = a; b1s = b; sm1s = sm; v1s = 1'b1;
        q1s.push_back(exp);
        step();
        chk("d1s_out_valid", 8'(ov1s), 8'd1);
    endtask

    task automatic drv8(input logic [7:0] a, input logic [7:0] b, input logic sm, input logic [2:0] exp);
        a8 = a; b8 = b; sm8 = sm; v8 = 1'b1;
        q8.push_back(exp);
        last8 = exp;
        step();
        chk("d8_out_valid", 8'(ov8), 8'd1);
    endtask

    initial begin
        logic [2:0] exp_leg;

        rst = 1'b1;
        a1u = 1'b1; b1u = 1'b0; sm1u = 1'b0; v1u = 1'b1;
        a1s = 1'b1; b1s = 1'b0; sm1s = 1'b1; v1s = 1'b1;
        a8 = 8'hFF; b8 = 8'h00; sm8 = 1'b0; v8 = 1'b1;
        last8 = 3'b000;

        // Monitor: pops the next expected result whenever an instance presents one.
        fork
            forever begin
                @(negedge clk);
                if (ov1u === 1'b1) begin
                    if (q1u.size() == 0) begin
                        chk("d1u_unexpected_out_valid", 8'(ov1u), 8'd0);
                    end else begin
                        exp_leg = q1u.pop_front();
                        chk("d1u_leg", 8'({l1u, e1u, g1u}), 8'(exp_leg));
                    end
                end
                if (ov1s === 1'b1) begin
                    if (q1s.size() == 0) begin
                        chk("d1s_unexpected_out_valid", 8'(ov1s), 8'd0);
                    end else begin
                        exp_leg = q1s.pop_front();
                        chk("d1s_leg", 8'({l1s, e1s, g1s}), 8'(exp_leg));
                    end
                end
                if (ov8 === 1'b1) begin
                    if (q8.size() == 0) begin
                        chk("d8_unexpected_out_valid", 8'(ov8), 8'd0);
                    end else begin
                        exp_leg = q8.pop_front();
                        chk("d8_leg", 8'({l8, e8, g8}), 8'(exp_leg));
                        chk("d8_onehot", 8'($countones({l8, e8, g8})), 8'd1);
                    end
                end
            end
        join_none

        // Reset held with in_valid=1: everything must stay cleared.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_d1u", 8'({l1u, e1u, g1u, ov1u}), 8'd0);
            chk("rst_d1s", 8'({l1s, e1s, g1s, ov1s}), 8'd0);
            chk("rst_d8",  8'({l8, e8, g8, ov8}), 8'd0);
        end

        // Released with in_valid=0: still no result.
        rst = 1'b0;
        idle_all();
        step();
        chk("post_rst_idle_d8", 8'({l8, e8, g8, ov8}), 8'd0);

        // 1-bit unsigned truth table; signed_mode must be ignored on this instance.
        drv1u(1'b0, 1'b0, 1'b0, 3'b010);
        drv1u(1'b0, 1'b1, 1'b0, 3'b100);
        drv1u(1'b1, 1'b0, 1'b0, 3'b001);
        drv1u(1'b1, 1'b1, 1'b0, 3'b010);
        drv1u(1'b1, 1'b0, 1'b1, 3'b001);
        drv1u(1'b0, 1'b1, 1'b1, 3'b100);
        idle_all();

        // 1-bit signed: value 1 is -1.
        drv1s(1'b1, 1'b0, 1'b1, 3'b100);
        drv1s(1'b0, 1'b1, 1'b1, 3'b001);
        drv1s(1'b1, 1'b1, 1'b1, 3'b010);
        drv1s(1'b1, 1'b0, 1'b0, 3'b001);
        idle_all();

        // 8-bit directed boundaries followed by a 10-deep back-to-back stream.
        drv8(8'h80, 8'h01, 1'b1, 3'b100);
        drv8(8'h80, 8'h01, 1'b0, 3'b001);
        drv8(8'hFF, 8'hFF, 1'b1, 3'b010);
        drv8(8'hFF, 8'hFF, 1'b0, 3'b010);
        drv8(8'h00, 8'hFF, 1'b0, 3'b100);
        drv8(8'h00, 8'hFF, 1'b1, 3'b001);
        drv8(8'h80, 8'h7F, 1'b1, 3'b100);
        drv8(8'h80, 8'h7F, 1'b0, 3'b001);
        drv8(8'h3C, 8'h3C, 1'b1, 3'b010);
        drv8(8'h7F, 8'h80, 1'b1, 3'b001);
        drv8(8'hFE, 8'hFF, 1'b1, 3'b100);
        drv8(8'h01, 8'hFE, 1'b1, 3'b001);
        drv8(8'h01, 8'hFE, 1'b0, 3'b100);
        drv8(8'hA5, 8'h5A, 1'b0, 3'b001);

        // Three idle cycles with changing operands: out_valid low, result held.
        idle_all();
        for (int i = 0; i < 3; i++) begin
            a8 = 8'(i); b8 = 8'hFF - 8'(i);
            step();
            chk("d8_idle_out_valid", 8'(ov8), 8'd0);
            chk("d8_idle_hold", 8'({l8, e8, g8}), 8'(last8));
        end

        // Reset in the middle of a stream; the operands in the reset cycle are dropped.
        drv8(8'h10, 8'h20, 1'b0, 3'b100);
        rst = 1'b1;
        a8 = 8'h20; b8 = 8'h10; v8 = 1'b1;
        step();
        chk("d8_midrst_clear", 8'({l8, e8, g8, ov8}), 8'd0);
        rst = 1'b0;
        drv8(8'h05, 8'h05, 1'b1, 3'b010);
        drv8(8'h20, 8'h10, 1'b0, 3'b001);

        idle_all();
        step();
        chk("d8_final_idle", 8'(ov8), 8'd0);
        step();
        chk("d1u_drain", 8'(q1u.size()), 8'd0);
        chk("d1s_drain", 8'(q1s.size()), 8'd0);
        chk("d8_drain",  8'(q8.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
